// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage in front of the opcode decoder. It owns the program
//   counter, fetches one word at a time over a request/response handshake,
//   holds it in the instruction register, and redirects the PC when the held
//   instruction retires.
//
//   Flow: IDLE -> REQ (wait for IMemReady) -> HOLD (wait for Stall=0) -> REQ
//
// Ports
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   IMemReady     memory response strobe, IMemData valid in the same cycle
//   IMemData      fetched instruction word
//   Stall         downstream not ready, so the held instruction may not retire
//   Jump, BranchEQ, BranchNE, Zero
//                 redirect controls for the held instruction (retire edge only)
//   IMemReq       fetch request, high for the whole REQ state
//   IMemAddr      fetch address, always equal to PC
//   PC, PC_4      current PC and PC+4
//   Instruction   instruction register ([31:26] is the decoder opcode)
//   InstrValid    Instruction holds a fetched word that has not yet retired
//   RetiredCount  retired-instruction counter, wraps at all-ones
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0040_0000,
   parameter int          COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   IMemReady,
   input  logic [31:0]            IMemData,
   input  logic                   Stall,
   input  logic                   Jump,
   input  logic                   BranchEQ,
   input  logic                   BranchNE,
   input  logic                   Zero,
   output logic                   IMemReq,
   output logic [31:0]            IMemAddr,
   output logic [31:0]            PC,
   output logic [31:0]            PC_4,
   output logic [31:0]            Instruction,
   output logic                   InstrValid,
   output logic [COUNT_WIDTH-1:0] RetiredCount
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [31:0]            r_pc;
   logic [31:0]            r_instr;
   logic [COUNT_WIDTH-1:0] r_count;

   logic                   w_req;
   logic                   w_valid;
   logic                   w_capture;
   logic                   w_retire;
   logic                   w_taken;
   logic [31:0]            w_pc_4;
   logic [31:0]            w_branch_off;
   logic [31:0]            w_branch_target;
   logic [31:0]            w_jump_target;
   logic [31:0]            w_next_pc;

   // ---------------------------------------------------------------------------
   // Next-state and handshake outputs
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default before the case, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_valid     = 1'b0;
      w_capture   = 1'b0;
      w_retire    = 1'b0;
      case (r_state)
         ST_IDLE: w_state_nxt = ST_REQ;
         ST_REQ: begin
            w_req = 1'b1;
            if (IMemReady) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_valid = 1'b1;
            if (!Stall) begin
               w_retire    = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-PC selection: Jump beats any branch; all adds wrap mod 2^32.
   // ---------------------------------------------------------------------------
   assign w_pc_4          = r_pc + 32'd4;
   assign w_taken         = (BranchEQ & Zero) | (BranchNE & ~Zero);
   assign w_branch_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_branch_target = w_pc_4 + w_branch_off;
   assign w_jump_target   = {w_pc_4[31:28], r_instr[25:0], 2'b00};
   assign w_next_pc       = Jump    ? w_jump_target   :
                            w_taken ? w_branch_target : w_pc_4;

   // ---------------------------------------------------------------------------
   // State, PC, instruction register, retire counter
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_instr <= IMemData;
         end
         // PC moves only on retire, so IMemAddr is stable throughout REQ.
         if (w_retire) begin
            r_pc    <= w_next_pc;
            r_count <= r_count + COUNT_WIDTH'(1);
         end
      end
   end

   assign IMemReq      = w_req;
   assign IMemAddr     = r_pc;
   assign PC           = r_pc;
   assign PC_4         = w_pc_4;
   assign Instruction  = r_instr;
   assign InstrValid   = w_valid;
   assign RetiredCount = r_count;

endmodule
